// File: rtl/lfa_arbiter.sv
// Round-robin arbiter time-sharing one Ladner-Fischer adder among 4 requesters.
// Optional signed-overflow output is compiled in with LFA_ARB_OVF_EN.

module lfadder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] s_list,
    output logic         c
);
    localparam int LVL = $clog2(W);

    logic [W-1:0] g [LVL+1];
    logic [W-1:0] p [LVL];

    assign g[0] = a & b;
    assign p[0] = a ^ b;

    // Sklansky-style prefix tree: bit i with bit l set merges the top of the lower half-block
    for (genvar l = 0; l < LVL; l++) begin : g_lvl
        for (genvar i = 0; i < W; i++) begin : g_bit
            if (((i >> l) & 1) == 1) begin : g_op
                localparam int J = ((i >> l) << l) - 1;
                assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][J]);
                if (l < LVL - 1) begin : g_p
                    assign p[l+1][i] = p[l][i] & p[l][J];
                end
            end else begin : g_pass
                assign g[l+1][i] = g[l][i];
                if (l < LVL - 1) begin : g_p
                    assign p[l+1][i] = p[l][i];
                end
            end
        end
    end

    assign s_list = p[0] ^ {g[LVL][W-2:0], 1'b0};
    assign c      = g[LVL][W-1];
endmodule

module lfa_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_id,
    output logic [DW-1:0]         rsp_sum,
    output logic                  rsp_cout,
    input  logic                  rsp_ready,
    output logic                  busy
`ifdef LFA_ARB_OVF_EN
    ,
    output logic                  rsp_ovf
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t        state, state_nxt;
    logic [1:0]    last_grant, win, idx;
    logic          found, accept;
    logic [DW-1:0] op_a, op_b, sum;
    logic [1:0]    op_id;
    logic          cout;

    lfadder #(.W(DW)) u_add (.a(op_a), .b(op_b), .s_list(sum), .c(cout));

    always_comb begin
        win   = last_grant;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last_grant + 2'(k);
            if (!found && req_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // Grant is suppressed while reset is asserted so nothing looks accepted.
    assign accept    = (state == IDLE) && rst_n && found;
    assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_id    = op_id;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = accept ? EXEC : IDLE;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= '0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
`ifdef LFA_ARB_OVF_EN
            rsp_ovf    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= win;
                op_a       <= req_a[{win, 5'd0} +: DW];
                op_b       <= req_b[{win, 5'd0} +: DW];
                op_id      <= win;
            end
            if (state == EXEC) begin
                rsp_sum  <= sum;
                rsp_cout <= cout;
`ifdef LFA_ARB_OVF_EN
                rsp_ovf  <= (op_a[DW-1] == op_b[DW-1]) & (sum[DW-1] != op_a[DW-1]);
`endif
            end
        end
    end
endmodule

// File: tb/tb_lfa_arbiter.sv
// Directed bench for lfa_arbiter with a response scoreboard.
// Build with LFA_ARB_OVF_EN to also check rsp_ovf.

module tb_lfa_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic         rsp_cout;
    logic         rsp_ready = 1'b0;
    logic         busy;
`ifdef LFA_ARB_OVF_EN
    logic         rsp_ovf;
`endif

    lfa_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_ready(rsp_ready), .busy(busy)
`ifdef LFA_ARB_OVF_EN
        , .rsp_ovf(rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } rsp_t;

    rsp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    logic [1:0] m_last = 2'd3;
    int         last_acc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_win(input logic [3:0] m);
        logic [1:0] idx;
        exp_win = m_last;
        for (int k = 4; k >= 1; k--) begin
            idx = m_last + 2'(k);
            if (m[idx]) exp_win = idx;
        end
    endfunction

    // One full transaction from the IDLE cycle; returns on the cycle after release.
    task automatic op(input logic [3:0] vmask, input int hold, input bit b2b);
        rsp_t        e;
        logic [1:0]  w;
        logic [31:0] a, b;
        logic [32:0] s;
        w = exp_win(vmask);
        req_valid = vmask;
        rsp_ready = 1'b1;
        #1;
        chk("grant", 64'(req_ready), 64'(4'b0001 << w));
        chk("idle_busy", 64'(busy), 64'(0));
        if (b2b) chk("accept_interval", 64'(cyc - last_acc), 64'(3));
        last_acc = cyc;
        a = req_a[32*w +: 32];
        b = req_b[32*w +: 32];
        s = {1'b0, a} + {1'b0, b};
        e.id = w; e.sum = s[31:0]; e.cout = s[32];
        e.ovf = (a[31] == b[31]) && (s[31] != a[31]);
        sb.push_back(e);
        m_last = w;
        @(negedge clk); #1;
        chk("exec_ready", 64'(req_ready), 64'(0));
        chk("exec_valid", 64'(rsp_valid), 64'(0));
        chk("exec_busy", 64'(busy), 64'(1));
        @(negedge clk);
        rsp_ready = (hold == 0);
        #1;
        e = sb.pop_front();
        chk("resp_valid", 64'(rsp_valid), 64'(1));
        chk("resp_id", 64'(rsp_id), 64'(e.id));
        chk("resp_sum", 64'(rsp_sum), 64'(e.sum));
        chk("resp_cout", 64'(rsp_cout), 64'(e.cout));
        chk("resp_ready", 64'(req_ready), 64'(0));
`ifdef LFA_ARB_OVF_EN
        chk("resp_ovf", 64'(rsp_ovf), 64'(e.ovf));
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            chk("hold_valid", 64'(rsp_valid), 64'(1));
            chk("hold_sum", 64'(rsp_sum), 64'(e.sum));
            chk("hold_cout", 64'(rsp_cout), 64'(e.cout));
            chk("hold_id", 64'(rsp_id), 64'(e.id));
            chk("hold_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("post_valid", 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_valid", 64'(rsp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_cout", 64'(rsp_cout), 64'(0));
        chk("rst_sum", 64'(rsp_sum), 64'(0));
        chk("rst_id", 64'(rsp_id), 64'(0));
`ifdef LFA_ARB_OVF_EN
        chk("rst_ovf", 64'(rsp_ovf), 64'(0));
`endif
        rst_n = 1'b1;
        req_valid = '0;
        @(negedge clk); #1;
        chk("idle_nobusy", 64'(busy), 64'(0));
        chk("idle_noready", 64'(req_ready), 64'(0));

        // Reference vector: carry out of a normal add
        req_a[31:0] = 32'h3a6f36e3;
        req_b[31:0] = 32'hf6af8732;
        op(4'b0001, 0, 1'b0);
        chk("vec_sum", 64'(rsp_sum), 64'(32'h311ebe15));
        chk("vec_cout", 64'(rsp_cout), 64'(1));

        // rsp_ready with no pending result does nothing
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("stray_rdy_busy", 64'(busy), 64'(0));
        chk("stray_rdy_valid", 64'(rsp_valid), 64'(0));

        // Signed overflow boundary
        req_a[95:64] = 32'h7fffffff;
        req_b[95:64] = 32'h00000001;
        op(4'b0100, 0, 1'b0);
        chk("ovf_sum", 64'(rsp_sum), 64'(32'h80000000));

        // Unsigned wrap with consumer back-pressure
        req_a[63:32] = 32'hffffffff;
        req_b[63:32] = 32'h00000001;
        op(4'b0010, 5, 1'b0);
        chk("wrap_sum", 64'(rsp_sum), 64'(0));

        // Arbiter re-evaluates combinationally while idle; withdrawn requests cost nothing
        req_valid = 4'b1000;
        #1 chk("reeval_a", 64'(req_ready), 64'(4'b0001 << exp_win(4'b1000)));
        req_valid = 4'b0001;
        #1 chk("reeval_b", 64'(req_ready), 64'(4'b0001 << exp_win(4'b0001)));
        req_valid = '0;
        @(negedge clk); #1;
        chk("withdraw_busy", 64'(busy), 64'(0));
        req_a[127:96] = $urandom;
        req_b[127:96] = $urandom;
        op(4'b1000, 2, 1'b0);

        // Round robin from reset with all requesters active
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 2'd3;
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = $urandom;
            req_b[32*i +: 32] = $urandom;
        end
        for (int i = 0; i < 5; i++) begin
            op(4'b1111, 0, i > 0);
            chk("rr_order", 64'(m_last), 64'(i % 4));
        end

        // Reset during EXEC drops the operation
        req_valid = 4'b1111;
        #1 chk("pre_rst_grant", 64'(req_ready), 64'(4'b0001 << exp_win(4'b1111)));
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rst_exec_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_exec_busy", 64'(busy), 64'(0));
        chk("rst_exec_valid", 64'(rsp_valid), 64'(0));
        m_last = 2'd3;
        op(4'b1111, 0, 1'b0);
        chk("post_rst_grant", 64'(m_last), 64'(0));

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lfa_arbiter.md
LFA_ARBITER -- requirements
Module: lfa_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-002 req_valid input 4: per-requester operand-valid, bit i is requester i.
REQ-003 req_a input 128: packed operand A, requester i at bits [32i+31:32i].
REQ-004 req_b input 128: packed operand B, same packing as req_a.
REQ-005 req_ready output 4: one-hot grant and accept strobe.
REQ-006 rsp_valid output 1: result available.
REQ-007 rsp_id output 2: index of the requester that owns the result.
REQ-008 rsp_sum output 32: registered 32-bit sum.
REQ-009 rsp_cout output 1: registered carry-out.
REQ-010 rsp_ready input 1: consumer accepts the result.
REQ-011 busy output 1: high in every state except IDLE.
REQ-012 rsp_ovf output 1: signed overflow; present only under LFA_ARB_OVF_EN.

Function
REQ-013 The block SHALL instantiate exactly one lfadder (a, b, s_list, c) and time-share it among 4 requesters.
REQ-014 FSM states SHALL be IDLE, EXEC and RESP; other encodings go to IDLE.
REQ-015 In IDLE with any req_valid high, req_ready SHALL assert combinationally for the single round-robin winner only; req_ready is all zeros in EXEC and RESP.
REQ-016 Round-robin: search starts at (last_grant+1) mod 4 and ascends with wrap; last_grant updates only on an accepted transfer.
REQ-017 On transfer (req_valid[i] & req_ready[i]), the block SHALL latch req_a/req_b slice i and id i into operand registers and go IDLE->EXEC.
REQ-018 In EXEC (exactly 1 cycle), the adder SHALL be driven only from the operand registers; at the end of EXEC, s_list->rsp_sum and c->rsp_cout are registered and the FSM goes to RESP.
REQ-019 In RESP, rsp_valid=1 with rsp_id/rsp_sum/rsp_cout held stable until rsp_ready=1; on that edge the FSM goes to IDLE.
REQ-020 Latency SHALL be fixed: rsp_valid is first high 2 cycles after the accept edge.
REQ-021 Throughput SHALL be at most one operation per 3 cycles; no new accept while in RESP, even if rsp_ready is high in the same cycle.
REQ-022 A requester dropping req_valid before grant SHALL lose nothing; the arbiter re-evaluates every IDLE cycle.
REQ-023 A sum wrap past 2^32 SHALL appear as rsp_cout=1 with the low 32 bits in rsp_sum.
REQ-024 rsp_ready while rsp_valid=0 SHALL be ignored.

Reset
REQ-025 With rst_n=0 at a clk edge, the state SHALL become IDLE, last_grant=3, and operand/result registers and rsp_id clear to 0.
REQ-026 During and after reset, req_ready=0, rsp_valid=0, busy=0, rsp_cout=0 and rsp_ovf=0 until the first accept.
REQ-027 Reset in EXEC or RESP SHALL discard the in-flight operation with no response.

Configuration
REQ-028 The macro LFA_ARB_OVF_EN SHALL compile in the rsp_ovf port and register.
REQ-029 With LFA_ARB_OVF_EN defined, rsp_ovf is registered with rsp_sum as (A[31]==B[31]) & (S[31]!=A[31]).
REQ-030 Without LFA_ARB_OVF_EN, the rsp_ovf port and logic SHALL be absent and all other behaviour is identical.

Verification
REQ-031 Reset, then req_valid=0001, A=3a6f36e3, B=f6af8732 -> req_ready=0001; 2 cycles later rsp_valid=1, rsp_id=0, rsp_sum=311ebe15, rsp_cout=1, rsp_ovf=0.
REQ-032 req_valid=1111 held and rsp_ready=1 -> grants in order 0,1,2,3,0, one accept per 3 cycles.
REQ-033 A=7fffffff, B=00000001 -> rsp_sum=80000000, rsp_cout=0, rsp_ovf=1 (when LFA_ARB_OVF_EN is defined).
REQ-034 A=ffffffff, B=00000001, rsp_ready=0 for 5 cycles -> rsp_sum=00000000, rsp_cout=1, outputs stable and req_ready=0 throughout; release on rsp_ready.
REQ-035 rst_n=0 during EXEC -> next cycle state is IDLE, rsp_valid=0, last_grant=3; the next grant with req_valid=1111 goes to requester 0.
